// File: rtl/mem_bus_port_pkg.sv
// Shared types and constants for mem_bus_port (package mem_bus_pkg).
// MEM_WRITE_VERIFY_EN adds the VERIFY state used for write read-back checking.
package mem_bus_pkg;

    localparam int WORD_W              = 16;
    localparam int DEFAULT_WAIT_STATES = 2;
    localparam int CNT_W               = 4;

    typedef logic [WORD_W-1:0] word_t;

`ifdef MEM_WRITE_VERIFY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        DONE   = 3'd3,
        VERIFY = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;
`endif

    // The counter holds "cycles remaining after this one", hence the -1.
    function automatic logic [CNT_W-1:0] ws_load_val(input int ws);
        return CNT_W'(ws - 1);
    endfunction

endpackage

// File: rtl/mem_bus_port_if.sv
// Bus bundle between the datapath/SRAM side (master) and mem_bus_port (slave).
// MEM_WRITE_VERIFY_EN adds the sticky Verify_Err status signal.
interface mem_bus_port_if;
    import mem_bus_pkg::*;

    // Handshake: the master raises Mem_Req (with Mem_WE) for one or more cycles;
    // it is accepted only on an edge where Busy is low. Busy stays high until
    // the transfer finishes, and Mem_Ready pulses for exactly one cycle at the end.
    word_t DataBus;
    logic  LD_MAR;
    logic  LD_MDR;
    logic  MIO_EN;
    logic  Mem_Req;
    logic  Mem_WE;
    word_t Data_from_SRAM;

    word_t ADDR;
    word_t Data_to_SRAM;
    word_t MAR;
    word_t MDR;
    logic  CE_n;
    logic  OE_n;
    logic  WE_n;
    logic  Busy;
    logic  Mem_Ready;

`ifdef MEM_WRITE_VERIFY_EN
    logic  Verify_Err;

    modport master (
        output DataBus, LD_MAR, LD_MDR, MIO_EN, Mem_Req, Mem_WE, Data_from_SRAM,
        input  ADDR, Data_to_SRAM, MAR, MDR, CE_n, OE_n, WE_n, Busy, Mem_Ready,
        input  Verify_Err
    );

    modport slave (
        input  DataBus, LD_MAR, LD_MDR, MIO_EN, Mem_Req, Mem_WE, Data_from_SRAM,
        output ADDR, Data_to_SRAM, MAR, MDR, CE_n, OE_n, WE_n, Busy, Mem_Ready,
        output Verify_Err
    );
`else
    modport master (
        output DataBus, LD_MAR, LD_MDR, MIO_EN, Mem_Req, Mem_WE, Data_from_SRAM,
        input  ADDR, Data_to_SRAM, MAR, MDR, CE_n, OE_n, WE_n, Busy, Mem_Ready
    );

    modport slave (
        input  DataBus, LD_MAR, LD_MDR, MIO_EN, Mem_Req, Mem_WE, Data_from_SRAM,
        output ADDR, Data_to_SRAM, MAR, MDR, CE_n, OE_n, WE_n, Busy, Mem_Ready
    );
`endif

endinterface

// File: rtl/mem_bus_port_ws_counter.sv
// ws_counter: loadable 4-bit down-counter with a zero flag, used to time SRAM accesses.
// Load has priority over decrement; the count saturates at zero.
module ws_counter
    import mem_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_bus_port.sv
// mem_bus_port: MAR/MDR registers plus an SRAM strobe sequencer (IDLE/SETUP/ACCESS/DONE).
// MEM_WRITE_VERIFY_EN adds a VERIFY read-back phase after writes and the Verify_Err flag.
module mem_bus_port
    import mem_bus_pkg::*;
#(
    // SRAM access cycles per transfer, legal range 1..15.
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
)
(
    input  logic          Clk,
    input  logic          Reset_n,
    mem_bus_port_if.slave bus,
    output state_t        state
);

    localparam logic [CNT_W-1:0] WS_LOAD = ws_load_val(WAIT_STATES);

    state_t state_q;
    state_t state_d;

    word_t mar_q;
    word_t mdr_q;
    logic  dir_q;

    logic  cnt_load;
    logic  cnt_dec;
    logic  cnt_zero;
    logic  last_access;
    logic  rd_capture;

    logic  ce_n;
    logic  oe_n;
    logic  we_n;
    logic  busy;
    logic  ready;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.Mem_Req) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_zero) begin
`ifdef MEM_WRITE_VERIFY_EN
                    state_d = dir_q ? VERIFY : DONE;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef MEM_WRITE_VERIFY_EN
            VERIFY: begin
                if (cnt_zero) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs (strobes decode straight from the state register, so
    // an asynchronous reset deasserts them immediately)
    // ---------------------------------------------------------------
    always_comb begin
        ce_n  = 1'b1;
        oe_n  = 1'b1;
        we_n  = 1'b1;
        busy  = 1'b1;
        ready = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
            end
            SETUP: begin
                ce_n = 1'b0;
            end
            ACCESS: begin
                ce_n = 1'b0;
                oe_n = dir_q;
                we_n = ~dir_q;
            end
`ifdef MEM_WRITE_VERIFY_EN
            VERIFY: begin
                ce_n = 1'b0;
                oe_n = 1'b0;
            end
`endif
            DONE: begin
                ready = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Wait-state counter
    // ---------------------------------------------------------------
    assign last_access = (state_q == ACCESS) && cnt_zero;

`ifdef MEM_WRITE_VERIFY_EN
    // Reload on the way into VERIFY so the read-back lasts WAIT_STATES cycles too.
    assign cnt_load = (state_q == SETUP) || (last_access && dir_q);
    assign cnt_dec  = ((state_q == ACCESS) || (state_q == VERIFY)) && !cnt_zero;
`else
    assign cnt_load = (state_q == SETUP);
    assign cnt_dec  = (state_q == ACCESS) && !cnt_zero;
`endif

    ws_counter u_ws_counter (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .load     (cnt_load),
        .load_val (WS_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // ---------------------------------------------------------------
    // MAR / MDR / direction. Loads are honoured only in IDLE so the
    // address and data stay frozen for the whole transfer.
    // ---------------------------------------------------------------
    assign rd_capture = last_access && !dir_q && bus.MIO_EN;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mar_q <= '0;
            mdr_q <= '0;
            dir_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (bus.LD_MAR) begin
                mar_q <= bus.DataBus;
            end
            if (bus.LD_MDR && !bus.MIO_EN) begin
                mdr_q <= bus.DataBus;
            end
            if (bus.Mem_Req) begin
                dir_q <= bus.Mem_WE;
            end
        end else if (rd_capture) begin
            mdr_q <= bus.Data_from_SRAM;
        end
    end

`ifdef MEM_WRITE_VERIFY_EN
    logic verify_err_q;

    // Sticky: once a read-back mismatches, only reset clears it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            verify_err_q <= 1'b0;
        end else if ((state_q == VERIFY) && cnt_zero &&
                     (bus.Data_from_SRAM != mdr_q)) begin
            verify_err_q <= 1'b1;
        end
    end

    assign bus.Verify_Err = verify_err_q;
`endif

    assign bus.ADDR         = mar_q;
    assign bus.Data_to_SRAM = mdr_q;
    assign bus.MAR          = mar_q;
    assign bus.MDR          = mdr_q;
    assign bus.CE_n         = ce_n;
    assign bus.OE_n         = oe_n;
    assign bus.WE_n         = we_n;
    assign bus.Busy         = busy;
    assign bus.Mem_Ready    = ready;
    assign state            = state_q;

endmodule

// File: doc/mem_bus_port.md
MEM_BUS_PORT -- requirements
Module: mem_bus_port

Interface
REQ-001 Parameter WAIT_STATES, default 2, SHALL set the number of SRAM access cycles per transfer (legal 1..15).
REQ-002 Clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 Reset_n  in  1  asynchronous, active-low reset.
REQ-004 DataBus  in  16  shared datapath bus; the value this block loads into MAR/MDR.
REQ-005 LD_MAR  in  1  load MAR from DataBus.
REQ-006 LD_MDR  in  1  load MDR (source selected by MIO_EN).
REQ-007 MIO_EN  in  1  1: MDR source is SRAM read data; 0: MDR source is DataBus.
REQ-008 Mem_Req  in  1  start one memory transfer.
REQ-009 Mem_WE  in  1  transfer direction, sampled with Mem_Req (1 = write, 0 = read).
REQ-010 Data_from_SRAM  in  16  SRAM read data.
REQ-011 ADDR  out  16  SRAM address, always equal to MAR.
REQ-012 Data_to_SRAM  out  16  SRAM write data, always equal to MDR.
REQ-013 MAR, MDR  out  16 each  register contents, for the bus-driver gate MDR_bus.
REQ-014 CE_n, OE_n, WE_n  out  1 each  active-low SRAM strobes.
REQ-015 Busy  out  1  high whenever the FSM is not IDLE.
REQ-016 Mem_Ready  out  1  single-cycle transfer-complete pulse.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, ACCESS, DONE (plus VERIFY when REQ-031 applies).
REQ-018 IDLE: Mem_Req=1 SHALL latch Mem_WE into an internal direction bit and go to SETUP; otherwise remain.
REQ-019 SETUP: CE_n=0, strobes OE_n/WE_n high; SHALL go to ACCESS next cycle and load the wait counter with WAIT_STATES-1.
REQ-020 ACCESS: CE_n=0; read drives OE_n=0, write drives WE_n=0; counter decrements each cycle; on counter=0 SHALL go to DONE.
REQ-021 Read: on the last ACCESS cycle, MDR SHALL capture Data_from_SRAM iff MIO_EN=1 at that edge; otherwise MDR unchanged.
REQ-022 DONE: all strobes high, Mem_Ready=1 for exactly one cycle, then IDLE.
REQ-023 Latency: Mem_Req sampled at edge k -> Mem_Ready high in cycle k+2+WAIT_STATES.
REQ-024 LD_MAR/LD_MDR in IDLE SHALL load on the same edge; LD_MDR with MIO_EN=0 loads DataBus; LD_MDR with MIO_EN=1 in IDLE is ignored.
REQ-025 LD_MAR, LD_MDR and Mem_Req asserted while Busy=1 SHALL be ignored (MAR/MDR stable throughout a transfer).
REQ-026 Mem_Req together with LD_MAR (and/or LD_MDR) in IDLE: loads take effect on that edge, so the transfer uses the new MAR/MDR.
REQ-027 Mem_Req held high after DONE SHALL start a new transfer from IDLE (one idle cycle between transfers).

Reset
REQ-028 Reset_n=0 SHALL immediately force IDLE, MAR=MDR=16'h0000, counter=0, CE_n=OE_n=WE_n=1, Busy=0, Mem_Ready=0, regardless of transfer in progress.
REQ-029 A transfer aborted by reset SHALL NOT be resumed; no Mem_Ready is issued for it.

Configuration
REQ-030 Macro MEM_WRITE_VERIFY_EN SHALL control write read-back checking.
REQ-031 Defined: after a write's ACCESS, FSM enters VERIFY for WAIT_STATES cycles (CE_n=0, OE_n=0), compares Data_from_SRAM to MDR on the last cycle, sets sticky output Verify_Err (1 bit, cleared only by reset) on mismatch, then DONE; MDR is not modified; write latency becomes 2+2*WAIT_STATES.
REQ-032 Undefined: no VERIFY state, no Verify_Err port; behaviour exactly REQ-017..REQ-029.

Structure
REQ-033 Package mem_bus_pkg SHALL hold the state enum, word width constant (16) and default wait-state constant.
REQ-034 Sub-module ws_counter (loadable 4-bit down-counter with zero flag) SHALL implement the wait counter.

Verification
REQ-035 Write: LD_MAR DataBus=16'h3000, LD_MDR MIO_EN=0 DataBus=16'hBEEF, Mem_Req Mem_WE=1 -> ADDR=3000, Data_to_SRAM=BEEF, WE_n low exactly 2 cycles, Mem_Ready 4 cycles after request.
REQ-036 Read: MAR=16'h3000, SRAM model returns 16'hBEEF, Mem_Req Mem_WE=0, MIO_EN=1 -> OE_n low 2 cycles, MDR=BEEF when Mem_Ready pulses.
REQ-037 Busy lockout: during read, LD_MAR DataBus=16'h1234 and second Mem_Req -> MAR stays 3000, only one Mem_Ready.
REQ-038 Same-edge: LD_MAR=16'h0042 with Mem_Req in IDLE -> ADDR=0042 in SETUP.
REQ-039 Reset mid-ACCESS -> strobes high, MAR=MDR=0, Busy=0 asynchronously, no Mem_Ready.
REQ-040 With MEM_WRITE_VERIFY_EN: SRAM model corrupts write 16'hBEEF to 16'hBEEE -> Verify_Err=1 and stays 1 after next good transfer.
